// File: rtl/div_pkg.sv
// Shared types and constants for the restoring divider and its add/sub datapath.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIV_W = 4;

    // Ceiling log2; the controller sizes its iteration counter with clog2(W+1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/addsub_unit.sv
// Ripple-carry adder/subtractor: sum = a + (b ^ {N{k}}) + k, cout is the carry out of the top bit.
module addsub_unit #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         k,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] carry;

    assign carry[0] = k;

    for (genvar gi = 0; gi < N; gi++) begin : g_bit
        logic bx;
        assign bx            = b[gi] ^ k;
        assign sum[gi]       = a[gi] ^ bx ^ carry[gi];
        assign carry[gi + 1] = (a[gi] & bx) | (carry[gi] & (a[gi] ^ bx));
    end

    assign cout = carry[N];

endmodule

// File: rtl/restoring_div_ctrl.sv
// Unsigned restoring divider: one quotient bit per clock through a shared add/sub unit
// held in subtract mode. Results are registered on entry to DONE and held until the next one.
module restoring_div_ctrl
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = clog2(W + 1);

    state_t        state_reg;
    state_t        state_next;

    logic [W:0]    r_reg;
    logic [W-1:0]  q_reg;
    logic [W-1:0]  d_reg;
    logic [CW-1:0] cnt_reg;

    logic [W-1:0]  quotient_reg;
    logic [W-1:0]  remainder_reg;
    logic          div_by_zero_reg;

    logic [2*W:0]  rq_shift;
    logic [W:0]    rs;
    logic [W-1:0]  qs;
    logic [W:0]    trial;
    logic          no_borrow;
    logic [W:0]    r_next;
    logic [W-1:0]  q_next;

    logic          accept;
    logic          last_iter;

    // {R,Q} << 1; R's top bit is always zero between iterations so dropping it loses nothing.
    assign rq_shift = {r_reg, q_reg} << 1;
    assign rs       = rq_shift[2*W:W];
    assign qs       = rq_shift[W-1:0];

    addsub_unit #(
        .N(W + 1)
    ) u_addsub (
        .a   (rs),
        .b   ({1'b0, d_reg}),
        .k   (1'b1),
        .sum (trial),
        .cout(no_borrow)
    );

    always_comb begin
        r_next = no_borrow ? trial : rs;
        q_next = qs | W'(no_borrow);
    end

    assign accept    = start && (state_reg != ITER);
    assign last_iter = (state_reg == ITER) && (cnt_reg == CW'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (divisor == '0) ? DONE : ITER;
                end
            end
            ITER: begin
                if (cnt_reg == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_next = (divisor == '0) ? DONE : ITER;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        busy = (state_reg == ITER);
        done = (state_reg == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg           <= '0;
            q_reg           <= '0;
            d_reg           <= '0;
            cnt_reg         <= '0;
            quotient_reg    <= '0;
            remainder_reg   <= '0;
            div_by_zero_reg <= 1'b0;
        end else if (accept) begin
            r_reg   <= '0;
            q_reg   <= dividend;
            d_reg   <= divisor;
            cnt_reg <= CW'(W);
            if (divisor == '0) begin
                quotient_reg    <= '1;
                remainder_reg   <= dividend;
                div_by_zero_reg <= 1'b1;
            end
        end else if (state_reg == ITER) begin
            r_reg   <= r_next;
            q_reg   <= q_next;
            cnt_reg <= cnt_reg - CW'(1);
            // Publish from the final iteration's combinational result so DONE sees it at once.
            if (last_iter) begin
                quotient_reg    <= q_next;
                remainder_reg   <= r_next[W-1:0];
                div_by_zero_reg <= 1'b0;
            end
        end
    end

    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = div_by_zero_reg;

endmodule

// File: tb/tb_restoring_div_ctrl.sv
// Self-checking bench for restoring_div_ctrl: directed table, multi-cycle corner cases,
// exhaustive 4-bit sweep and randomized back-to-back traffic against an arithmetic model.
module tb_restoring_div_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int vectors     = 0;
    int miscompares = 0;

    int hold_q = 0;
    int hold_r = 0;
    int hold_z = 0;

    typedef struct {
        int    a;
        int    b;
        int    q;
        int    r;
        int    z;
        string tag;
    } vec_t;

    vec_t table_v[8];

    always #5 clk = ~clk;

    restoring_div_ctrl #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model(input int a, input int b, output int q, output int r, output int z);
        if (b == 0) begin
            q = (1 << W) - 1;
            r = a;
            z = 1;
        end else begin
            q = a / b;
            r = a % b;
            z = 0;
        end
    endfunction

    // Counts edges from a start request until done; optionally pulses a second start at edge inj_edge.
    task automatic wait_done(input string tag, input int inj_edge, input int inj_a, input int inj_b,
                             output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            start = (n == inj_edge);
            if (n == inj_edge) begin
                dividend = W'(inj_a);
                divisor  = W'(inj_b);
            end
            if (done) begin
                lat = n;
                break;
            end
            if (busy) busy_cnt++;
            chk({tag, " held quotient"}, int'(quotient), hold_q);
            chk({tag, " held remainder"}, int'(remainder), hold_r);
            chk({tag, " held dbz"}, int'(div_by_zero), hold_z);
        end
    endtask

    task automatic run_op(input string tag, input int a, input int b, input int eq, input int er,
                          input int ez, input int inj_edge, input int inj_a, input int inj_b);
        int lat;
        int bc;
        start    = 1'b1;
        dividend = W'(a);
        divisor  = W'(b);
        wait_done(tag, inj_edge, inj_a, inj_b, lat, bc);
        chk({tag, " latency"}, lat, (b == 0) ? 1 : W + 1);
        chk({tag, " busy cycles"}, bc, (b == 0) ? 0 : W);
        chk({tag, " quotient"}, int'(quotient), eq);
        chk({tag, " remainder"}, int'(remainder), er);
        chk({tag, " dbz"}, int'(div_by_zero), ez);
        $display("op %s: %0d/%0d -> q=%0d r=%0d dbz=%0d lat=%0d", tag, a, b,
                 quotient, remainder, div_by_zero, lat);
        hold_q = eq;
        hold_r = er;
        hold_z = ez;
    endtask

    task automatic run_model_op(input string tag, input int a, input int b);
        int q;
        int r;
        int z;
        model(a, b, q, r, z);
        run_op(tag, a, b, q, r, z, 0, 0, 0);
    endtask

    // One idle cycle after done: the pulse must drop and results must stay put.
    task automatic idle_check(input string tag);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, " done pulse"}, int'(done), 0);
        chk({tag, " idle busy"}, int'(busy), 0);
        chk({tag, " idle quotient"}, int'(quotient), hold_q);
        chk({tag, " idle remainder"}, int'(remainder), hold_r);
        chk({tag, " idle dbz"}, int'(div_by_zero), hold_z);
    endtask

    initial begin
        int done_seen;

        table_v[0] = '{13, 3, 4, 1, 0, "13/3"};
        table_v[1] = '{3, 9, 0, 3, 0, "3/9"};
        table_v[2] = '{15, 1, 15, 0, 0, "15/1"};
        table_v[3] = '{7, 0, 15, 7, 1, "7/0"};
        table_v[4] = '{0, 5, 0, 0, 0, "0/5"};
        table_v[5] = '{15, 15, 1, 0, 0, "15/15"};
        table_v[6] = '{1, 15, 0, 1, 0, "1/15"};
        table_v[7] = '{0, 0, 15, 0, 1, "0/0"};

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset quotient", int'(quotient), 0);
        chk("reset remainder", int'(remainder), 0);
        chk("reset dbz", int'(div_by_zero), 0);

        // Reset wins over a simultaneous start.
        start    = 1'b1;
        dividend = 4'd13;
        divisor  = 4'd3;
        @(posedge clk);
        #1;
        chk("rst priority busy", int'(busy), 0);
        chk("rst priority done", int'(done), 0);
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("after rst busy", int'(busy), 0);

        for (int i = 0; i < 8; i++) begin
            run_op(table_v[i].tag, table_v[i].a, table_v[i].b, table_v[i].q, table_v[i].r,
                   table_v[i].z, 0, 0, 0);
            idle_check(table_v[i].tag);
        end

        // A start pulse during ITER must be ignored; then a start in the done cycle chains with no gap.
        run_op("12/5 ignore", 12, 5, 2, 2, 0, 3, 9, 2);
        run_op("9/2 chained", 9, 2, 4, 1, 0, 0, 0, 0);
        idle_check("9/2 chained");

        // Reset mid-operation discards everything.
        start    = 1'b1;
        dividend = 4'd14;
        divisor  = 4'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk("abort quotient", int'(quotient), 0);
        chk("abort remainder", int'(remainder), 0);
        chk("abort dbz", int'(div_by_zero), 0);
        hold_q = 0;
        hold_r = 0;
        hold_z = 0;
        done_seen = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        chk("abort no done", done_seen, 0);
        run_op("14/4 fresh", 14, 4, 3, 2, 0, 0, 0, 0);
        idle_check("14/4 fresh");

        // Exhaustive sweep, alternating idle gaps and back-to-back starts.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_model_op($sformatf("sweep %0d/%0d", a, b), a, b);
                if (((a + b) & 1) == 1) idle_check("sweep");
            end
        end
        idle_check("sweep end");

        for (int i = 0; i < 40; i++) begin
            int a;
            int b;
            a = int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 15));
            run_model_op($sformatf("rand %0d", i), a, b);
            if ($urandom_range(0, 1) == 1) idle_check("rand");
        end
        idle_check("rand end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/restoring_div_ctrl.md
Name: restoring_div_ctrl

Overview:
Sequencer that drives a shared add/subtract datapath to perform unsigned restoring division, one quotient bit per clock. It accepts a dividend/divisor pair on a start pulse and runs W shift-and-trial-subtract iterations through the add/sub unit. It returns quotient, remainder and a divide-by-zero flag with a one-cycle done pulse. It sits beside the 4-bit adder/subtractor as its first multi-cycle client.

Parameters:
W, 4, operand width in bits for dividend, divisor, quotient and remainder (W >= 2).

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  synchronous active-high reset.
start  in  1  request; sampled only while busy=0.
dividend  in  W  numerator; captured on an accepted start.
divisor  in  W  denominator; captured on an accepted start.
busy  out  1  high while iterating (ITER state).
done  out  1  one-cycle pulse; results valid from this cycle.
quotient  out  W  registered result, held until the next done.
remainder  out  W  registered result, held until the next done.
div_by_zero  out  1  registered; qualifies the current quotient/remainder.

Behaviour:
- Interface (decided): one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal R, Q, D and cnt are cleared.
- Reset asserted mid-operation aborts the division and discards all work.
- Reset has priority over start in the same cycle.
- States (3): IDLE, ITER, DONE. busy=1 only in ITER. done=1 only in DONE.
- IDLE or DONE with start=1:
  - Load R=0 (W+1 bits), Q=dividend, D=divisor, cnt=W.
  - If divisor==0: go to DONE and set div_by_zero=1, quotient={W{1}}, remainder=dividend. Latency is 1 cycle.
  - Else: go to ITER.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE. DONE accepts start, so back-to-back operations carry no idle gap.
- ITER, each cycle:
  - Form {Rs,Qs} = {R,Q} << 1, with Rs being W+1 bits.
  - Compute trial = Rs + ~{0,D} + 1 through the add/sub unit in subtract mode (k=1).
  - If carry-out=1 (no borrow): R=trial[W:0], Q[0]=1. Else: R=Rs, Q[0]=0.
  - Decrement cnt. When cnt reaches 1, the next state is DONE.
- On the ITER->DONE edge: quotient=Q, remainder=R[W-1:0], div_by_zero=0.
- Latency: done is high in the cycle W+1 edges after the edge that sampled start (5 cycles for W=4).
- start asserted while busy=1 is ignored: no capture and no effect.
- Outputs change only on entry to DONE or on reset. They are stable at all other times, including during a following operation until its done.
- Arithmetic is unsigned throughout. R never exceeds D-1 after an iteration, so R[W] is always 0 on completion.

Decomposition:
- Shared package div_pkg holds:
  - the state enum {IDLE, ITER, DONE};
  - the default width constant DIV_W=4;
  - the counter width function clog2(W+1).
- One sub-module, addsub_unit (parameter N=W+1):
  - inputs a[N], b[N], k;
  - outputs sum[N], cout;
  - function: sum = a + (b ^ {N{k}}) + k, with cout the true carry out of bit N-1.
- The controller instantiates addsub_unit once with k tied to 1. The controller contains no other arithmetic beyond the counter.

Test Plan:
- Reset, then start with dividend=13, divisor=3 -> busy high for 4 cycles; done at cycle 5; quotient=4, remainder=1, div_by_zero=0.
- dividend=3, divisor=9 -> quotient=0, remainder=3. dividend=15, divisor=1 -> quotient=15, remainder=0.
- dividend=7, divisor=0 -> done 1 cycle after start, busy never high; div_by_zero=1, quotient=15, remainder=7.
- start with 12/5, then pulse start with 9/2 during ITER -> second request ignored; result 2 rem 2. Re-assert start during the done cycle with 9/2 -> 4 rem 1 at done 5 cycles later, no gap.
- Start 14/4, assert rst at cycle 2 -> next cycle: busy=0, done=0, outputs 0. No done pulse follows. A fresh start 14/4 then yields 3 rem 2.
- Exhaustive sweep of all 256 operand pairs for W=4 against a golden model (/ and %; divisor 0 -> 15 and dividend). Checks cover latency, a single done pulse per operation, and outputs held between operations.
